// File: rtl/idp_decoder_27.sv
// Iterative decoder for 27-bit IDP (Mosaic 3C1S) FNS codewords: MSB group resolved by table,
// then the 23 FNS-weighted digits are accumulated CHUNK bits per cycle.
module idp_decoder_27 #(
  parameter int CHUNK = 4,
  parameter int DW    = 20
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [26:0]   codein,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] dataout,
  output logic          code_err
);

  localparam int NBITS = 23;
  localparam logic [5:0] CH6 = 6'(CHUNK);

  // FNS(n): 1, 2, 3, 5, 8, ... (FNS(n) = FNS(n-1) + FNS(n-2))
  function automatic logic [DW-1:0] fns(input int n);
    logic [DW-1:0] a, b, t;
    a = DW'(1);
    b = DW'(2);
    for (int k = 1; k < n; k++) begin
      t = a + b;
      a = b;
      b = t;
    end
    return a;
  endfunction

  function automatic logic [NBITS*DW-1:0] build_weights();
    logic [NBITS*DW-1:0] tab;
    tab = '0;
    for (int k = 0; k < NBITS; k++) tab[k*DW +: DW] = fns(k + 1);
    return tab;
  endfunction

  localparam logic [NBITS*DW-1:0] WEIGHTS = build_weights();
  localparam logic [DW-1:0] FNS24 = fns(24);
  localparam logic [DW-1:0] FNS26 = fns(26);
  localparam logic [DW-1:0] FNS27 = fns(27);

  typedef enum logic [1:0] {IDLE, ACC, DONE} state_t;

  state_t            state_q, state_d;
  logic [NBITS-1:0]  code_q, code_d;
  logic [DW-1:0]     acc_q, acc_d;
  logic [5:0]        idx_q, idx_d;
  logic              err_q, err_d;
  logic [DW-1:0]     dataout_q, dataout_d;
  logic              code_err_q, code_err_d;

  logic [DW-1:0]     offset;
  logic              illegal;
  logic [DW-1:0]     chunk_sum;
  logic [5:0]        bit_idx;
  logic [5:0]        next_idx;

  // Illegal MSB groups still decode their digits, with zero offset and the error flag raised
  always_comb begin
    offset  = '0;
    illegal = 1'b0;
    case (codein[26:23])
      4'b0000: offset = '0;
      4'b0001: offset = FNS24;
      4'b1000: offset = FNS26;
      4'b1001: offset = FNS24 + FNS26;
      4'b0011: offset = FNS24 + FNS27;
      4'b1100: offset = FNS26 + FNS27;
      4'b0110: offset = FNS27 + FNS27;
      4'b0111: offset = FNS27 + FNS27 + FNS24;
      4'b1110: offset = FNS27 + FNS27 + FNS26;
      4'b1111: offset = FNS27 + FNS27 + FNS26 + FNS24;
      default: illegal = 1'b1;
    endcase
  end

  always_comb begin
    chunk_sum = '0;
    bit_idx   = '0;
    for (int j = 0; j < CHUNK; j++) begin
      bit_idx = idx_q + 6'(j);
      if (bit_idx < 6'd23 && code_q[bit_idx[4:0]])
        chunk_sum = chunk_sum + WEIGHTS[int'(bit_idx[4:0])*DW +: DW];
    end
  end

  always_comb begin
    state_d    = state_q;
    code_d     = code_q;
    acc_d      = acc_q;
    idx_d      = idx_q;
    err_d      = err_q;
    dataout_d  = dataout_q;
    code_err_d = code_err_q;
    next_idx   = idx_q + CH6;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          code_d  = codein[22:0];
          acc_d   = offset;
          idx_d   = '0;
          err_d   = illegal;
          state_d = ACC;
        end
      end
      ACC: begin
        acc_d = acc_q + chunk_sum;
        idx_d = next_idx;
        if (next_idx >= 6'd23) begin
          dataout_d  = acc_q + chunk_sum;
          code_err_d = err_q;
          state_d    = DONE;
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= IDLE;
      code_q     <= '0;
      acc_q      <= '0;
      idx_q      <= '0;
      err_q      <= 1'b0;
      dataout_q  <= '0;
      code_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      code_q     <= code_d;
      acc_q      <= acc_d;
      idx_q      <= idx_d;
      err_q      <= err_d;
      dataout_q  <= dataout_d;
      code_err_q <= code_err_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign dataout   = dataout_q;
  assign code_err  = code_err_q;

endmodule

// File: tb/tb_idp_decoder_27.sv
// Bench for idp_decoder_27: directed checks on CHUNK=4, then random codewords through
// CHUNK=1/4/23 instances against an arithmetic FNS reference model.
module tb_idp_decoder_27;

  localparam int DW = 20;

  logic        clock = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        out_ready;
  logic [26:0] codein;

  logic          in_ready_c4, out_valid_c4, code_err_c4;
  logic [DW-1:0] dataout_c4;
  logic          in_ready_c1, out_valid_c1, code_err_c1;
  logic [DW-1:0] dataout_c1;
  logic          in_ready_c23, out_valid_c23, code_err_c23;
  logic [DW-1:0] dataout_c23;

  int n_cmp = 0;
  int n_err = 0;
  int w [1:27];

  always #5 clock = ~clock;

  idp_decoder_27 #(.CHUNK(4), .DW(DW)) u_dut4 (
    .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(in_ready_c4),
    .codein(codein), .out_valid(out_valid_c4), .out_ready(out_ready),
    .dataout(dataout_c4), .code_err(code_err_c4));

  idp_decoder_27 #(.CHUNK(1), .DW(DW)) u_dut1 (
    .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(in_ready_c1),
    .codein(codein), .out_valid(out_valid_c1), .out_ready(out_ready),
    .dataout(dataout_c1), .code_err(code_err_c1));

  idp_decoder_27 #(.CHUNK(23), .DW(DW)) u_dut23 (
    .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(in_ready_c23),
    .codein(codein), .out_valid(out_valid_c23), .out_ready(out_ready),
    .dataout(dataout_c23), .code_err(code_err_c23));

  function automatic bit ref_illegal(input logic [26:0] cw);
    int m;
    m = int'(cw[26:23]);
    return (m == 2 || m == 4 || m == 5 || m == 10 || m == 11 || m == 13);
  endfunction

  // Value = MSB-group offset + sum of FNS(k+1) over set digit bits, modulo 2^DW
  function automatic int ref_value(input logic [26:0] cw);
    longint total;
    total = 0;
    case (int'(cw[26:23]))
      1:  total = w[24];
      8:  total = w[26];
      9:  total = w[24] + w[26];
      3:  total = w[24] + w[27];
      12: total = w[26] + w[27];
      6:  total = 2 * w[27];
      7:  total = 2 * w[27] + w[24];
      14: total = 2 * w[27] + w[26];
      15: total = 2 * w[27] + w[26] + w[24];
      default: total = 0;
    endcase
    for (int k = 0; k < 23; k++) if (cw[k]) total += w[k + 1];
    return int'(total % (longint'(1) << DW));
  endfunction

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Present a word for one edge, then count edges until the CHUNK=4 decoder reports a result
  task automatic apply_stimulus(input logic [26:0] cw, output int lat);
    codein   = cw;
    in_valid = 1'b1;
    @(posedge clock); #1;
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid_c4 && lat < 40) begin
      @(posedge clock); #1;
      lat++;
    end
  endtask

  task automatic release_result();
    out_ready = 1'b1;
    @(posedge clock); #1;
    out_ready = 1'b0;
  endtask

  initial begin
    int lat;
    int exp_v;
    logic [26:0] cw;
    logic [DW-1:0] held;
    logic [3:0] legal_msb [10];
    logic [3:0] msb;

    legal_msb = '{4'h0, 4'h1, 4'h8, 4'h9, 4'h3, 4'hC, 4'h6, 4'h7, 4'hE, 4'hF};
    w[1] = 1;
    w[2] = 2;
    for (int k = 3; k <= 27; k++) w[k] = w[k-1] + w[k-2];

    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0; codein = '0;
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b0;
    check_output("reset_in_ready", 32'(in_ready_c4), 32'd1);
    check_output("reset_out_valid", 32'(out_valid_c4), 32'd0);
    check_output("reset_dataout", 32'(dataout_c4), 32'd0);
    check_output("reset_code_err", 32'(code_err_c4), 32'd0);

    apply_stimulus(27'h0, lat);
    check_output("zero_latency", 32'(lat), 32'd6);
    check_output("zero_dataout", 32'(dataout_c4), 32'd0);
    check_output("zero_code_err", 32'(code_err_c4), 32'd0);
    release_result();

    apply_stimulus(27'h0000001, lat);
    check_output("fns01_dataout", 32'(dataout_c4), 32'd1);
    release_result();

    apply_stimulus({4'b0001, 23'h0}, lat);
    check_output("fns24_dataout", 32'(dataout_c4), 32'(w[24]));
    check_output("fns24_code_err", 32'(code_err_c4), 32'd0);
    release_result();

    apply_stimulus({4'b0101, 23'h3}, lat);
    check_output("illegal_dataout", 32'(dataout_c4), 32'd3);
    check_output("illegal_code_err", 32'(code_err_c4), 32'd1);
    release_result();

    cw = {4'b1111, 23'h2AAAAA};
    apply_stimulus(cw, lat);
    held = dataout_c4;
    check_output("hold_dataout", 32'(held), 32'(ref_value(cw)));
    for (int i = 0; i < 5; i++) begin
      codein   = 27'h1234567;
      in_valid = 1'b1;
      @(posedge clock); #1;
      check_output("hold_out_valid", 32'(out_valid_c4), 32'd1);
      check_output("hold_stable", 32'(dataout_c4), 32'(held));
      check_output("hold_in_ready", 32'(in_ready_c4), 32'd0);
    end
    in_valid = 1'b0;
    release_result();
    check_output("release_in_ready", 32'(in_ready_c4), 32'd1);
    check_output("release_out_valid", 32'(out_valid_c4), 32'd0);

    codein   = {4'b0110, 23'h155555};
    in_valid = 1'b1;
    @(posedge clock); #1;
    in_valid = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b1;
    @(posedge clock); #1;
    reset = 1'b0;
    check_output("midreset_out_valid", 32'(out_valid_c4), 32'd0);
    check_output("midreset_in_ready", 32'(in_ready_c4), 32'd1);
    check_output("midreset_dataout", 32'(dataout_c4), 32'd0);
    cw = {4'b1001, 23'h012345};
    apply_stimulus(cw, lat);
    check_output("after_reset_dataout", 32'(dataout_c4), 32'(ref_value(cw)));
    check_output("after_reset_latency", 32'(lat), 32'd6);
    release_result();

    // Realign all three widths to IDLE before the shared random phase
    reset = 1'b1;
    @(posedge clock); #1;
    reset = 1'b0;

    for (int n = 0; n < 600; n++) begin
      msb = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : legal_msb[$urandom_range(0, 9)];
      cw  = {msb, 23'($urandom)};
      exp_v = ref_value(cw);
      codein   = cw;
      in_valid = 1'b1;
      @(posedge clock); #1;
      in_valid = 1'b0;
      lat = 0;
      while (!(out_valid_c1 && out_valid_c4 && out_valid_c23) && lat < 40) begin
        @(posedge clock); #1;
        lat++;
      end
      check_output("rand_all_valid", 32'(out_valid_c1 & out_valid_c4 & out_valid_c23), 32'd1);
      check_output("rand_c1_data", 32'(dataout_c1), 32'(exp_v));
      check_output("rand_c4_data", 32'(dataout_c4), 32'(exp_v));
      check_output("rand_c23_data", 32'(dataout_c23), 32'(exp_v));
      check_output("rand_c1_err", 32'(code_err_c1), 32'(ref_illegal(cw)));
      check_output("rand_c4_err", 32'(code_err_c4), 32'(ref_illegal(cw)));
      check_output("rand_c23_err", 32'(code_err_c23), 32'(ref_illegal(cw)));
      release_result();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
